// File: rtl/ram_browser.sv
// ram_browser: RAM browse/edit engine for the Nexys4DDR board.
//
// Holds a 2^AW x DW synchronous RAM and an address pointer. The pointer moves
// on debounced button edges (or auto-scans); a write button stores din at the
// pointer, reads it back and checks it. addr/dout drive the 7-segment display.
//
// Optional feature macro: RAM_BROWSER_AUTO_SCAN_EN
//   defined   - scan_en=1 auto-increments the pointer every SCAN_TICKS ticks
//   undefined - no scan logic; scan_en is ignored
//
// Ports:
//   clk      in   system clock (100 MHz)
//   reset    in   asynchronous active-low reset
//   step_up  in   raw button, increment pointer
//   step_dn  in   raw button, decrement pointer
//   we_btn   in   raw button, write din at pointer
//   scan_en  in   level switch, auto-scan mode
//   din      in   [DW-1:0] data to write
//   addr     out  [AW-1:0] current pointer
//   dout     out  [DW-1:0] registered RAM word at addr
//   busy     out  write/verify sequence in progress
//   wr_done  out  one-cycle pulse at end of write/verify
//   wr_err   out  sticky read-back mismatch flag
module ram_browser #(
  parameter int AW         = 8,
  parameter int DW         = 16,
  parameter int TICK_DIV   = 100000,
  parameter int SCAN_TICKS = 500
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step_up,
  input  logic          step_dn,
  input  logic          we_btn,
  input  logic          scan_en,
  input  logic [DW-1:0] din,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] dout,
  output logic          busy,
  output logic          wr_done,
  output logic          wr_err
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, WR, RD, CHK} state_t;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Button vectors are ordered {we, dn, up}.
  logic [2:0]    sync1_q, sync1_d, sync2_q, sync2_d, samp_q, samp_d;
  logic [2:0]    edge_w;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  state_t        state_q, state_d;
  logic [DW-1:0] din_q, din_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          busy_q, busy_d;
  logic          wr_done_q, wr_done_d;
  logic          wr_err_q, wr_err_d;

`ifdef RAM_BROWSER_AUTO_SCAN_EN
  localparam int SW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_TICKS - 1);
  logic          scan_s1_q, scan_s1_d, scan_s2_q, scan_s2_d;
  logic [SW-1:0] scan_cnt_q, scan_cnt_d;
`else
  logic unused_scan_en;
  assign unused_scan_en = scan_en;
`endif

  always_comb begin
    tick       = (tick_cnt_q == TICK_MAX);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

    sync1_d = {we_btn, step_dn, step_up};
    sync2_d = sync1_q;
    // Sampling only on tick debounces; an edge is a 0->1 between samples.
    samp_d  = tick ? sync2_q : samp_q;
    edge_w  = tick ? (sync2_q & ~samp_q) : 3'b000;

    state_d  = state_q;
    din_d    = din_q;
    addr_d   = addr_q;
    dout_d   = mem[addr_q];
    wr_err_d = wr_err_q;

`ifdef RAM_BROWSER_AUTO_SCAN_EN
    scan_s1_d  = scan_en;
    scan_s2_d  = scan_s1_q;
    scan_cnt_d = scan_s2_q ? scan_cnt_q : '0;
`endif

    case (state_q)
      IDLE: begin
        if (edge_w[2]) begin
          // Write wins; any step edge in the same tick is dropped.
          state_d = WR;
          din_d   = din;
        end else begin
`ifdef RAM_BROWSER_AUTO_SCAN_EN
          if (scan_s2_q) begin
            if (tick) begin
              if (scan_cnt_q == SCAN_MAX) begin
                scan_cnt_d = '0;
                addr_d     = addr_q + AW'(1);
              end else begin
                scan_cnt_d = scan_cnt_q + SW'(1);
              end
            end
          end else if (edge_w[0] ^ edge_w[1]) begin
            addr_d = edge_w[0] ? addr_q + AW'(1) : addr_q - AW'(1);
          end
`else
          if (edge_w[0] ^ edge_w[1]) begin
            addr_d = edge_w[0] ? addr_q + AW'(1) : addr_q - AW'(1);
          end
`endif
        end
      end
      WR:  state_d = RD;
      RD:  state_d = CHK;
      CHK: begin
        state_d = IDLE;
        if (dout_q != din_q) wr_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    wr_done_d = (state_d == CHK);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      samp_q     <= '0;
      state_q    <= IDLE;
      din_q      <= '0;
      addr_q     <= '0;
      dout_q     <= '0;
      busy_q     <= 1'b0;
      wr_done_q  <= 1'b0;
      wr_err_q   <= 1'b0;
`ifdef RAM_BROWSER_AUTO_SCAN_EN
      scan_s1_q  <= 1'b0;
      scan_s2_q  <= 1'b0;
      scan_cnt_q <= '0;
`endif
    end else begin
      tick_cnt_q <= tick_cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      samp_q     <= samp_d;
      state_q    <= state_d;
      din_q      <= din_d;
      addr_q     <= addr_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      wr_done_q  <= wr_done_d;
      wr_err_q   <= wr_err_d;
`ifdef RAM_BROWSER_AUTO_SCAN_EN
      scan_s1_q  <= scan_s1_d;
      scan_s2_q  <= scan_s2_d;
      scan_cnt_q <= scan_cnt_d;
`endif
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (state_q == WR) mem[addr_q] <= din_q;
  end

  assign addr    = addr_q;
  assign dout    = dout_q;
  assign busy    = busy_q;
  assign wr_done = wr_done_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_ram_browser.sv
module tb_ram_browser;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        up = 0, dn = 0, we = 0, scan = 0;
  logic [15:0] din = '0;
  logic [7:0]  addr;
  logic [15:0] dout;
  logic        busy, done, err;

  logic        up_s = 0, dn_s = 0, we_s = 0, scan_s = 0;
  logic [15:0] din_s = '0;
  logic [7:0]  addr_s;
  logic [15:0] dout_s;
  logic        busy_s, done_s, err_s;

  int n_cmp = 0;
  int n_err = 0;
  int busy_cnt, done_cnt;

  always #5 clk = ~clk;

  ram_browser #(.AW(8), .DW(16), .TICK_DIV(4), .SCAN_TICKS(500)) dut (
    .clk(clk), .reset(reset_n), .step_up(up), .step_dn(dn), .we_btn(we),
    .scan_en(scan), .din(din), .addr(addr), .dout(dout), .busy(busy),
    .wr_done(done), .wr_err(err)
  );

  ram_browser #(.AW(8), .DW(16), .TICK_DIV(2), .SCAN_TICKS(3)) dut_s (
    .clk(clk), .reset(reset_n), .step_up(up_s), .step_dn(dn_s), .we_btn(we_s),
    .scan_en(scan_s), .din(din_s), .addr(addr_s), .dout(dout_s), .busy(busy_s),
    .wr_done(done_s), .wr_err(err_s)
  );

  // Drive a button combination for hold cycles, release for rel cycles,
  // counting busy and wr_done cycles of the selected instance.
  task automatic press(input bit s, input bit u, input bit d, input bit w,
                       input int hold, input int rel,
                       input bit chg, input logic [15:0] alt);
    busy_cnt = 0;
    done_cnt = 0;
    if (s) begin up_s = u; dn_s = d; we_s = w; end
    else   begin up = u;   dn = d;   we = w;   end
    for (int i = 0; i < hold + rel; i++) begin
      if (i == hold) begin
        up = 0; dn = 0; we = 0; up_s = 0; dn_s = 0; we_s = 0;
      end
      @(posedge clk); #1;
      if (s ? busy_s : busy) begin
        busy_cnt++;
        if (chg) begin
          if (s) din_s = alt; else din = alt;
        end
      end
      if (s ? done_s : done) done_cnt++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (addr !== 8'h00)  begin n_err++; $display("FAIL reset_addr: got %h want 00", addr); end
    n_cmp++; if (dout !== 16'h0)  begin n_err++; $display("FAIL reset_dout: got %h want 0000", dout); end
    n_cmp++; if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0)   begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (err !== 1'b0)    begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++; if (addr_s !== 8'h00) begin n_err++; $display("FAIL reset_addr_s: got %h want 00", addr_s); end
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_write();
    din = 16'hBEEF;
    press(0, 0, 0, 1, 12, 12, 1, 16'h1234);
    n_cmp++; if (busy_cnt != 3)     begin n_err++; $display("FAIL wr_busy_cycles: got %0d want 3", busy_cnt); end
    n_cmp++; if (done_cnt != 1)     begin n_err++; $display("FAIL wr_done_pulses: got %0d want 1", done_cnt); end
    n_cmp++; if (dout !== 16'hBEEF) begin n_err++; $display("FAIL wr_dout: got %h want beef", dout); end
    n_cmp++; if (err !== 1'b0)      begin n_err++; $display("FAIL wr_err: got %b want 0", err); end
    n_cmp++; if (addr !== 8'h00)    begin n_err++; $display("FAIL wr_addr: got %h want 00", addr); end
    din = 16'hCAFE;
    press(0, 0, 0, 1, 12, 12, 0, 16'h0);
    n_cmp++; if (done_cnt != 1)     begin n_err++; $display("FAIL wr2_done_pulses: got %0d want 1", done_cnt); end
    n_cmp++; if (dout !== 16'hCAFE) begin n_err++; $display("FAIL wr2_dout: got %h want cafe", dout); end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    din = 16'h0A0A;
    we = 1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (busy) begin found = 1; break; end
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL mid_busy_seen: got 0 want 1");
      we = 0;
    end else begin
      // now in WR; one more edge reaches RD
      @(posedge clk); #1;
      reset_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0)  begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
      n_cmp++; if (dout !== 16'h0) begin n_err++; $display("FAIL mid_dout: got %h want 0000", dout); end
      we = 0;
      done_cnt = 0;
      repeat (3) begin @(posedge clk); #1; if (done) done_cnt++; end
      reset_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (dout !== 16'h0A0A) begin n_err++; $display("FAIL mid_readback: got %h want 0a0a", dout); end
      n_cmp++; if (addr !== 8'h00)    begin n_err++; $display("FAIL mid_addr: got %h want 00", addr); end
      repeat (12) begin @(posedge clk); #1; if (done) done_cnt++; end
      n_cmp++; if (done_cnt != 0)     begin n_err++; $display("FAIL mid_no_done: got %0d want 0", done_cnt); end
    end
  endtask

  task automatic test_step();
    press(0, 0, 1, 0, 12, 12, 0, 16'h0);
    n_cmp++; if (addr !== 8'hFF) begin n_err++; $display("FAIL step_dn_wrap: got %h want ff", addr); end
    press(0, 1, 0, 0, 12, 12, 0, 16'h0);
    press(0, 1, 0, 0, 12, 12, 0, 16'h0);
    n_cmp++; if (addr !== 8'h01) begin n_err++; $display("FAIL step_up_wrap: got %h want 01", addr); end
    press(0, 1, 1, 0, 12, 12, 0, 16'h0);
    n_cmp++; if (addr !== 8'h01) begin n_err++; $display("FAIL step_both: got %h want 01", addr); end
    repeat (4) press(0, 1, 0, 0, 12, 12, 0, 16'h0);
    n_cmp++; if (addr !== 8'h05) begin n_err++; $display("FAIL step_to_5: got %h want 05", addr); end
  endtask

  task automatic test_we_priority();
    din = 16'h5555;
    press(0, 1, 0, 1, 12, 12, 0, 16'h0);
    n_cmp++; if (addr !== 8'h05)    begin n_err++; $display("FAIL prio_addr: got %h want 05", addr); end
    n_cmp++; if (dout !== 16'h5555) begin n_err++; $display("FAIL prio_dout: got %h want 5555", dout); end
    n_cmp++; if (done_cnt != 1)     begin n_err++; $display("FAIL prio_done: got %0d want 1", done_cnt); end
  endtask

  // With TICK_DIV=2 a step raised two cycles after we_btn is first seen on
  // the tick that falls in the RD state.
  task automatic test_busy_discard();
    done_cnt = 0;
    din_s = 16'h7777;
    we_s = 1;
    repeat (2) begin @(posedge clk); #1; if (done_s) done_cnt++; end
    up_s = 1;
    repeat (10) begin @(posedge clk); #1; if (done_s) done_cnt++; end
    we_s = 0; up_s = 0;
    repeat (10) begin @(posedge clk); #1; if (done_s) done_cnt++; end
    n_cmp++; if (addr_s !== 8'h00)    begin n_err++; $display("FAIL busy_addr: got %h want 00", addr_s); end
    n_cmp++; if (dout_s !== 16'h7777) begin n_err++; $display("FAIL busy_dout: got %h want 7777", dout_s); end
    n_cmp++; if (done_cnt != 1)       begin n_err++; $display("FAIL busy_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_scan();
    logic [7:0] last, v1, v2;
    int nchg, t1, t2;
    press(1, 0, 1, 0, 6, 6, 0, 16'h0);
    press(1, 0, 1, 0, 6, 6, 0, 16'h0);
    n_cmp++; if (addr_s !== 8'hFE) begin n_err++; $display("FAIL scan_start: got %h want fe", addr_s); end
    last = addr_s; v1 = '0; v2 = '0; nchg = 0; t1 = 0; t2 = 0;
    scan_s = 1;
    for (int i = 0; i < 40; i++) begin
`ifdef RAM_BROWSER_AUTO_SCAN_EN
      if (i == 3) dn_s = 1;
      if (i == 9) dn_s = 0;
`endif
      @(posedge clk); #1;
      if (addr_s !== last) begin
        nchg++;
        if (nchg == 1) begin v1 = addr_s; t1 = i; end
        if (nchg == 2) begin v2 = addr_s; t2 = i; end
        last = addr_s;
      end
    end
    scan_s = 0;
    dn_s = 0;
`ifdef RAM_BROWSER_AUTO_SCAN_EN
    n_cmp++; if (v1 !== 8'hFF)  begin n_err++; $display("FAIL scan_first: got %h want ff", v1); end
    n_cmp++; if (v2 !== 8'h00)  begin n_err++; $display("FAIL scan_second: got %h want 00", v2); end
    n_cmp++; if (t2 - t1 != 6)  begin n_err++; $display("FAIL scan_spacing: got %0d want 6", t2 - t1); end
`else
    n_cmp++; if (nchg != 0)         begin n_err++; $display("FAIL scan_off_moves: got %0d want 0", nchg); end
    n_cmp++; if (addr_s !== 8'hFE)  begin n_err++; $display("FAIL scan_off_addr: got %h want fe", addr_s); end
`endif
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_write();
    test_reset_mid();
    test_step();
    test_we_priority();
    test_busy_discard();
    test_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_browser.md
Name: ram_browser

Overview:
Parameterised RAM browse/edit engine for the Nexys4DDR board.
- Holds a 2^AW x DW synchronous RAM and an address pointer.
- Pointer moves up or down on debounced button edges, or auto-scans in scan mode.
- A write button stores din at the pointer, then reads it back and checks it.
- addr and dout feed the existing seven-segment display controller directly.

Parameters:
AW, 8, address width; RAM depth is 2^AW words.
DW, 16, data word width.
TICK_DIV, 100000, clk cycles per sample tick (1 kHz at 100 MHz); minimum 2.
SCAN_TICKS, 500, sample ticks between auto-scan steps; minimum 1.

Ports:
clk  in  1  system clock, 100 MHz.
reset  in  1  asynchronous, active-low reset.
step_up  in  1  raw push button: increment pointer.
step_dn  in  1  raw push button: decrement pointer.
we_btn  in  1  raw push button: write din at pointer.
scan_en  in  1  level switch: auto-scan mode.
din  in  DW  switch data to write.
addr  out  AW  current pointer.
dout  out  DW  registered RAM word at addr.
busy  out  1  write/verify sequence in progress.
wr_done  out  1  one-cycle pulse when a write/verify sequence ends.
wr_err  out  1  sticky read-back mismatch flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - addr=0, dout=0, busy=0, wr_done=0, wr_err=0.
  - Tick counter cleared, scan counter cleared, FSM to IDLE, button history cleared.
  - RAM contents are not cleared.
- Tick: free-running counter 0..TICK_DIV-1; a one-cycle tick strobe is asserted at count TICK_DIV-1.
- Buttons: each button passes through a 2-flop synchroniser and is sampled only on tick. An edge is registered when the previous sample is 0 and the current sample is 1. There is one edge per press, whatever the hold length.
- Edge priority within one tick:
  - we_btn edge: the write sequence starts and any step edges are discarded.
  - step_up and step_dn together: no move.
- Edges arriving while busy=1 are discarded.
- Pointer:
  - Changes on the clk edge after the tick on which the step edge is detected.
  - Modulo 2^AW: max+1 wraps to 0; 0-1 wraps to max.
- Scan mode (scan_en=1, busy=0):
  - Manual step edges are ignored.
  - Scan counter counts ticks; at SCAN_TICKS it clears and addr increments with wrap.
  - scan_en=0 clears the scan counter.
  - busy=1 freezes the scan counter.
- Read path:
  - dout <= mem[addr] every cycle, so 1-cycle latency after any addr change.
  - dout is 0 only from reset until the first clock.
- Write FSM, states IDLE -> WR -> RD -> CHK -> IDLE, one cycle each:
  - IDLE: on we_btn edge, latch din into din_q and go to WR.
  - WR: mem[addr] <= din_q; busy=1.
  - RD: read issued; busy=1.
  - CHK: compare dout with din_q; on mismatch set wr_err; wr_done=1 for this cycle; busy=1.
  - busy is high exactly 3 cycles.
  - addr is frozen from WR through CHK.
  - din changes after the latch have no effect.
- wr_err clears only on reset.
- Reset mid-sequence: FSM returns to IDLE immediately; a completed WR cycle stays in RAM.

Optional Feature:
RAM_BROWSER_AUTO_SCAN_EN:
- Defined: scan mode works as described.
- Undefined: no scan counter logic; scan_en is ignored and the pointer moves only on manual steps. The port list is unchanged.

Test Plan:
- TICK_DIV=4. Pulse reset low for 3 cycles -> addr=0, dout=0, busy=0, wr_err=0. Deassert -> dout equals mem[0] one cycle later.
- din=16'hBEEF at addr=0. Press we_btn for 3 ticks -> busy high exactly 3 cycles; wr_done pulses once; wr_err=0; dout=16'hBEEF after CHK. A second write needs release and re-press.
- From addr=0, press step_dn once -> addr=8'hFF. Press step_up twice -> addr=8'h01. step_up and step_dn in the same tick -> addr unchanged.
- Press we_btn and step_up in the same tick at addr=5 -> write lands at 5; addr stays 5. step_up pressed while busy -> addr stays 5.
- TICK_DIV=2, SCAN_TICKS=3, scan_en=1 from addr=8'hFE -> addr goes FE, FF, 00 at 6-cycle spacing; manual step_dn is ignored. With the macro undefined, addr does not move.
- Assert reset in the RD state -> busy=0 and wr_done never pulses. After release, mem[addr] holds the written din.
